// File: rtl/seq_detector_param.sv
// seq_detector_param: parametrised serial sequence detector.
// Flags each occurrence of PATTERN on the serial input w with a one-cycle
// registered pulse on z. Overlap/non-overlap matching is chosen per edge by ovl.
// Optional build feature: define SEQDET_HITCNT_EN to implement the saturating
// hit counter on hit_cnt; when undefined hit_cnt is tied to zero.
module seq_detector_param #(
    parameter int unsigned           PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0]  PATTERN   = 4'b1010,
    parameter int unsigned           CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             ovl,
    input  logic             w,
    output logic             z,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam int unsigned         HIST_W   = PATTERN_W - 1;
    localparam int unsigned         FILL_W   = $clog2(PATTERN_W + 1);
    localparam logic [FILL_W-1:0]   FILL_MAX = FILL_W'(PATTERN_W - 1);

    typedef enum logic [1:0] {
        PH_EMPTY   = 2'd0,
        PH_FILLING = 2'd1,
        PH_ARMED   = 2'd2
    } phase_t;

    logic [HIST_W-1:0]    r_hist;
    logic [FILL_W-1:0]    r_fill;
    logic                 r_z;

    logic [HIST_W-1:0]    w_hist_nxt;
    logic [FILL_W-1:0]    w_fill_nxt;
    logic                 w_z_nxt;
    logic [PATTERN_W-1:0] w_window;
    logic                 w_match;
    phase_t               w_phase;

    // Decode the fill counter into the detector phase
    always_comb begin
        w_phase = PH_FILLING;
        if (r_fill == '0) begin
            w_phase = PH_EMPTY;
        end else if (r_fill >= FILL_MAX) begin
            w_phase = PH_ARMED;
        end
    end

    // State register: shift history, fill count and the registered match pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hist <= '0;
            r_fill <= '0;
            r_z    <= 1'b0;
        end else begin
            r_hist <= w_hist_nxt;
            r_fill <= w_fill_nxt;
            r_z    <= w_z_nxt;
        end
    end

    // Next-state: clear beats stall beats sample; z only pulses on a sampled match
    always_comb begin
        w_hist_nxt = r_hist;
        w_fill_nxt = r_fill;
        w_z_nxt    = 1'b0;
        w_window   = {r_hist, w};
        w_match    = 1'b0;
        if (clr) begin
            w_hist_nxt = '0;
            w_fill_nxt = '0;
        end else if (en) begin
            w_match    = (w_phase == PH_ARMED) && (w_window == PATTERN);
            w_hist_nxt = w_window[HIST_W-1:0];
            w_z_nxt    = w_match;
            if (w_match) begin
                // Non-overlap restart discards every bit already seen
                w_fill_nxt = ovl ? FILL_MAX : '0;
            end else if (w_phase == PH_ARMED) begin
                w_fill_nxt = FILL_MAX;
            end else begin
                w_fill_nxt = FILL_W'(r_fill + 1'b1);
            end
        end
    end

    assign z = r_z;

`ifdef SEQDET_HITCNT_EN
    logic [CNT_W-1:0] r_cnt;

    // Saturating count of matches; cleared together with the history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (w_match && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= CNT_W'(r_cnt + 1'b1);
        end
    end

    assign hit_cnt = r_cnt;
`else
    assign hit_cnt = {CNT_W{1'b0}};
`endif

endmodule
